arashi_alloc_queue: RTL and testbench

- Multi-thread slot allocator and circular queue. Each cycle, up to THREAD_NUM threads request a write. Requesters are ranked, each accepted one gets a contiguous slot at tail+rank, and the tail advances by the number accepted.
- Unlike the fixed 4-bit, 4-thread allocator, this block adds the following:
  - parametrised thread count and depth;
  - on-chip storage;
  - single-port in-order dequeue with valid/ready;
  - full/empty backpressure with partial grant.
- Sits between the thread array and the shared memory/writeback stage.

---
 rtl/arashi_alloc_queue.sv | 133 +++++++++++++
 tb/tb_arashi_alloc_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/arashi_alloc_queue.sv
// Multi-thread slot allocator feeding an on-chip circular queue with a single in-order read port.
// Optional rotating request priority is enabled by defining ARASHI_ALLOC_ROTATE_EN.
module arashi_alloc_queue #(
    parameter int THREAD_NUM = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [THREAD_NUM-1:0]            wr,
    input  logic [DATA_WIDTH*THREAD_NUM-1:0] wdata,
    output logic [THREAD_NUM-1:0]            wgrant,
    output logic [DEPTH_LOG2*THREAD_NUM-1:0] waddr,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [DATA_WIDTH-1:0]            rd_data,
    output logic [DEPTH_LOG2:0]              count,
    output logic                             full,
    output logic                             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int RW    = $clog2(THREAD_NUM + 1);
    localparam int AW    = DEPTH_LOG2 * THREAD_NUM;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         free;
    logic [CW-1:0]         ngrant;
    logic                  pop;

    // Requests and grants in priority order: position 0 is the highest-priority thread.
    logic [THREAD_NUM-1:0] req;
    logic [THREAD_NUM-1:0] gnt_lin;
    logic [AW-1:0]         addr_lin;

    // free uses the count before any same-cycle pop, so popping never opens grant room.
    assign free = CW'(DEPTH) - count_q;

    always_comb begin : rank_grant
        logic [RW-1:0] acc;
        acc      = '0;
        gnt_lin  = '0;
        addr_lin = '0;
        ngrant   = '0;
        for (int k = 0; k < THREAD_NUM; k++) begin
            addr_lin[k*DEPTH_LOG2 +: DEPTH_LOG2] = tail + DEPTH_LOG2'(acc);
            if (rstn && req[k] && (CW'(acc) < free)) begin
                gnt_lin[k] = 1'b1;
                ngrant     = ngrant + CW'(1);
            end
            if (req[k]) begin
                acc = acc + RW'(1);
            end
        end
    end

`ifdef ARASHI_ALLOC_ROTATE_EN
    localparam int PW = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1;

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] first_denied;
    logic          any_denied;

    // Rotate requests so rr_ptr lands at position 0, then rotate results back to thread order.
    assign req    = THREAD_NUM'({wr, wr} >> rr_ptr);
    assign wgrant = THREAD_NUM'(({gnt_lin, gnt_lin} << rr_ptr) >> THREAD_NUM);
    assign waddr  = AW'(({addr_lin, addr_lin} << (int'(rr_ptr) * DEPTH_LOG2)) >> AW);

    always_comb begin : denied_scan
        int idx;
        idx        = 0;
        any_denied = 1'b0;
        for (int k = THREAD_NUM - 1; k >= 0; k--) begin
            if (req[k] && !gnt_lin[k]) begin
                any_denied = 1'b1;
                idx        = int'(rr_ptr) + k;
            end
        end
        if (idx >= THREAD_NUM) begin
            idx = idx - THREAD_NUM;
        end
        first_denied = PW'(idx);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (any_denied) begin
            rr_ptr <= first_denied;
        end
    end
`else
    assign req    = wr;
    assign wgrant = gnt_lin;
    assign waddr  = addr_lin;
`endif

    // Read handshake: an entry transfers on every rising edge where rd_valid and rd_ready are
    // both high; rd_valid never depends on rd_ready and rd_data holds until the entry is popped.
    assign rd_valid = (count_q != '0);
    assign rd_data  = mem[head];
    assign pop      = rd_valid && rd_ready;

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            tail    <= tail + DEPTH_LOG2'(ngrant);
            head    <= head + DEPTH_LOG2'(pop);
            count_q <= count_q + ngrant - CW'(pop);
        end
    end

    // Storage is not reset; grants are forced low during reset so nothing is written then.
    always_ff @(posedge clk) begin
        for (int i = 0; i < THREAD_NUM; i++) begin
            if (wgrant[i]) begin
                mem[waddr[i*DEPTH_LOG2 +: DEPTH_LOG2]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_arashi_alloc_queue.sv
// Directed, table-driven bench for arashi_alloc_queue: per-cycle vectors plus reset/drain sequences.
// Expected values for the rotating-priority build are selected with ARASHI_ALLOC_ROTATE_EN.
module tb_arashi_alloc_queue;

    localparam int T = 8;
    localparam int W = 32;
    localparam int D = 5;
    localparam int NV = 30;

`ifdef ARASHI_ALLOC_ROTATE_EN
    localparam logic [T-1:0] G_ONE_FREE_A = 8'h04;
    localparam logic [T-1:0] G_ONE_FREE_B = 8'h08;
`else
    localparam logic [T-1:0] G_ONE_FREE_A = 8'h01;
    localparam logic [T-1:0] G_ONE_FREE_B = 8'h01;
`endif

    logic           clk = 1'b0;
    logic           rstn;
    logic [T-1:0]   wr;
    logic [W*T-1:0] wdata;
    logic [T-1:0]   wgrant;
    logic [D*T-1:0] waddr;
    logic           rd_valid;
    logic           rd_ready;
    logic [W-1:0]   rd_data;
    logic [D:0]     count;
    logic           full;
    logic           empty;

    arashi_alloc_queue #(.THREAD_NUM(T), .DATA_WIDTH(W), .DEPTH_LOG2(D)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr       (wr),
        .wdata    (wdata),
        .wgrant   (wgrant),
        .waddr    (waddr),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic         rst;
        logic [T-1:0] wr;
        logic         rd_ready;
        logic [W-1:0] base;
        logic [T-1:0] exp_wgrant;
        logic [D-1:0] exp_slot0;
        logic         exp_rd_valid;
        logic [D:0]   exp_count;
        logic         drain_after;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic rst, input logic [T-1:0] w, input logic rd,
                                input logic [W-1:0] base, input logic [T-1:0] g,
                                input logic [D-1:0] slot0, input logic rv,
                                input logic [D:0] cnt, input logic drn);
        vec_t v;
        v.rst = rst; v.wr = w; v.rd_ready = rd; v.base = base; v.exp_wgrant = g;
        v.exp_slot0 = slot0; v.exp_rd_valid = rv; v.exp_count = cnt; v.drain_after = drn;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        wr = '0;
        rd_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        int k;
        logic [D-1:0] exp_addr;
        if (v.rst) do_reset();
        @(negedge clk);
        wr = v.wr;
        rd_ready = v.rd_ready;
        for (int i = 0; i < T; i++) wdata[i*W +: W] = v.base + W'(i);
        #1;
        check($sformatf("v%0d wgrant", idx), wgrant, v.exp_wgrant);
        check($sformatf("v%0d rd_valid", idx), rd_valid, v.exp_rd_valid);
        if (v.exp_rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL v%0d scoreboard: got empty expected queue entry", idx);
            end else if (v.rd_ready) begin
                check($sformatf("v%0d rd_data", idx), rd_data, exp_q.pop_front());
            end else begin
                check($sformatf("v%0d rd_data", idx), rd_data, exp_q[0]);
            end
        end
        k = 0;
        for (int i = 0; i < T; i++) begin
            if (v.exp_wgrant[i]) begin
                exp_addr = v.exp_slot0 + D'(k);
                check($sformatf("v%0d waddr[%0d]", idx, i), waddr[i*D +: D], exp_addr);
                exp_q.push_back(v.base + W'(i));
                k++;
            end
        end
        @(posedge clk);
        #1;
        check($sformatf("v%0d count", idx), count, v.exp_count);
        check($sformatf("v%0d full", idx), full, v.exp_count == 6'd32);
        check($sformatf("v%0d empty", idx), empty, v.exp_count == 6'd0);
        if (v.drain_after) drain(idx);
    endtask

    // Scoreboard drain: pops until the expected queue is empty
    task automatic drain(input int idx);
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
            @(negedge clk);
            wr = '0;
            rd_ready = 1'b1;
            #1;
            check($sformatf("d%0d rd_valid", idx), rd_valid, 1'b1);
            check($sformatf("d%0d rd_data", idx), rd_data, exp_q.pop_front());
            @(posedge clk);
            #1;
            check($sformatf("d%0d count", idx), count, exp_q.size());
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL d%0d drain budget: got %0d left expected 0", idx, exp_q.size());
        end
        rd_ready = 1'b0;
        check($sformatf("d%0d empty", idx), empty, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        wr = '0;
        wdata = '0;
        rd_ready = 1'b0;

        // rst, wr, rd, base, exp_wgrant, slot0, rd_valid, count, drain
        vecs[0]  = mk(1, 8'hA5, 0, 32'h200, 8'hA5, 5'd0,  0, 6'd4,  0);
        vecs[1]  = mk(0, 8'h00, 1, 32'h0,   8'h00, 5'd0,  1, 6'd3,  0);
        vecs[2]  = mk(0, 8'h00, 1, 32'h0,   8'h00, 5'd0,  1, 6'd2,  0);
        vecs[3]  = mk(0, 8'h00, 1, 32'h0,   8'h00, 5'd0,  1, 6'd1,  0);
        vecs[4]  = mk(0, 8'h00, 1, 32'h0,   8'h00, 5'd0,  1, 6'd0,  0);
        vecs[5]  = mk(0, 8'h00, 1, 32'h0,   8'h00, 5'd0,  0, 6'd0,  0);
        vecs[6]  = mk(1, 8'hFF, 0, 32'h100, 8'hFF, 5'd0,  0, 6'd8,  0);
        for (int i = 7; i <= 14; i++)
            vecs[i] = mk(0, 8'h00, 1, 32'h0, 8'h00, 5'd0, 1, 6'(14 - i), 0);
        vecs[15] = mk(0, 8'h00, 1, 32'h0,   8'h00, 5'd0,  0, 6'd0,  0);
        vecs[16] = mk(0, 8'hFF, 0, 32'h300, 8'hFF, 5'd8,  0, 6'd8,  0);
        vecs[17] = mk(0, 8'hFF, 0, 32'h310, 8'hFF, 5'd16, 1, 6'd16, 0);
        vecs[18] = mk(0, 8'hFF, 0, 32'h320, 8'hFF, 5'd24, 1, 6'd24, 0);
        vecs[19] = mk(0, 8'h3F, 0, 32'h330, 8'h3F, 5'd0,  1, 6'd30, 0);
        vecs[20] = mk(0, 8'hFF, 0, 32'h340, 8'h03, 5'd6,  1, 6'd32, 0);
        vecs[21] = mk(0, 8'hFF, 1, 32'h350, 8'h00, 5'd8,  1, 6'd31, 0);
        vecs[22] = mk(0, 8'hFF, 0, 32'h360, G_ONE_FREE_A, 5'd8, 1, 6'd32, 0);
        vecs[23] = mk(0, 8'hFF, 1, 32'h370, 8'h00, 5'd9,  1, 6'd31, 0);
        vecs[24] = mk(0, 8'hFF, 0, 32'h380, G_ONE_FREE_B, 5'd9, 1, 6'd32, 0);
        vecs[25] = mk(1, 8'hFF, 0, 32'h400, 8'hFF, 5'd0,  0, 6'd8,  0);
        vecs[26] = mk(0, 8'hFF, 0, 32'h410, 8'hFF, 5'd8,  1, 6'd16, 0);
        vecs[27] = mk(0, 8'hFF, 0, 32'h420, 8'hFF, 5'd16, 1, 6'd24, 0);
        vecs[28] = mk(0, 8'h3F, 0, 32'h430, 8'h3F, 5'd24, 1, 6'd30, 1);
        vecs[29] = mk(0, 8'h0F, 0, 32'h500, 8'h0F, 5'd30, 0, 6'd4,  1);

        // Reset state with all threads requesting
        #2;
        wr = '1;
        #1;
        check("reset wgrant", wgrant, 8'h00);
        check("reset rd_valid", rd_valid, 1'b0);
        check("reset count", count, 6'd0);
        check("reset empty", empty, 1'b1);
        check("reset full", full, 1'b0);
        wr = '0;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) apply_vec(i, vecs[i]);

        // Asynchronous reset between edges with twelve entries queued
        apply_vec(100, mk(1, 8'hFF, 0, 32'h700, 8'hFF, 5'd0, 0, 6'd8,  0));
        apply_vec(101, mk(0, 8'h0F, 0, 32'h710, 8'h0F, 5'd8, 1, 6'd12, 0));
        @(negedge clk);
        wr = 8'hFF;
        rd_ready = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        check("async count", count, 6'd0);
        check("async rd_valid", rd_valid, 1'b0);
        check("async wgrant", wgrant, 8'h00);
        check("async empty", empty, 1'b1);
        check("async full", full, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        wr = '0;
        rd_ready = 1'b0;
        exp_q.delete();
        apply_vec(102, mk(0, 8'h01, 0, 32'h720, 8'h01, 5'd0, 0, 6'd1, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
